// File: rtl/pwm_generator_if.sv
// Edge-position inputs and drive/strobe outputs of one PWM output channel.
// The master side supplies counter and edges; the slave side produces the waveform.
interface pwm_generator_if #(
  parameter int WIDTH = 13
);
  logic [WIDTH-1:0] CYCLE;
  logic [WIDTH-1:0] TIME_CNT;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic             OUT_EN;
  logic             PWM_OUT;
  logic             RISE_STB;
  logic             FALL_STB;

  modport master (
    output CYCLE, TIME_CNT, RISE, FALL, OUT_EN,
    input  PWM_OUT, RISE_STB, FALL_STB
  );

  modport slave (
    input  CYCLE, TIME_CNT, RISE, FALL, OUT_EN,
    output PWM_OUT, RISE_STB, FALL_STB
  );
endinterface

// File: rtl/pwm_generator.sv
// PWM output stage: compares the shared cycle counter against latched RISE/FALL
// edges (including wrap-around pulses) and emits edge strobes; 2-cycle latency.
module pwm_generator #(
  parameter int WIDTH = 13
) (
  input logic              CLK,
  input logic              RST_N,
  pwm_generator_if.slave   bus
);

  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             en_q, en_d;
  logic             rise_lt_fall_q, rise_lt_fall_d;
  logic             rise_eq_fall_q, rise_eq_fall_d;
  logic             pwm_q, pwm_d;
  logic             rise_stb_q, rise_stb_d;
  logic             fall_stb_q, fall_stb_d;
  logic             hi_s;

  // Stage 1: capture counter, edges and enable, and pre-compare the edges.
  always_comb begin
    t_d            = bus.TIME_CNT;
    rise_d         = bus.RISE;
    fall_d         = bus.FALL;
    en_d           = bus.OUT_EN;
    rise_lt_fall_d = (bus.RISE < bus.FALL);
    rise_eq_fall_d = (bus.RISE == bus.FALL);
  end

  // Stage 2: high-window decode; pwm_q doubles as the previous output for the strobes.
  always_comb begin
    hi_s = 1'b0;
    if (rise_eq_fall_q) begin
      hi_s = 1'b0;
    end else if (rise_lt_fall_q) begin
      hi_s = (t_q >= rise_q) && (t_q < fall_q);
    end else begin
      hi_s = (t_q >= rise_q) || (t_q < fall_q);
    end
    pwm_d      = hi_s & en_q;
    rise_stb_d = pwm_d & ~pwm_q;
    fall_stb_d = ~pwm_d & pwm_q;
  end

  // Pipeline and output registers, all cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      t_q            <= '0;
      rise_q         <= '0;
      fall_q         <= '0;
      en_q           <= 1'b0;
      rise_lt_fall_q <= 1'b0;
      rise_eq_fall_q <= 1'b0;
      pwm_q          <= 1'b0;
      rise_stb_q     <= 1'b0;
      fall_stb_q     <= 1'b0;
    end else begin
      t_q            <= t_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      en_q           <= en_d;
      rise_lt_fall_q <= rise_lt_fall_d;
      rise_eq_fall_q <= rise_eq_fall_d;
      pwm_q          <= pwm_d;
      rise_stb_q     <= rise_stb_d;
      fall_stb_q     <= fall_stb_d;
    end
  end

  assign bus.PWM_OUT  = pwm_q;
  assign bus.RISE_STB = rise_stb_q;
  assign bus.FALL_STB = fall_stb_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: stimulus pushes expected outputs, a monitor
// pops and compares every cycle; directed windows check counts and edge positions.
module tb_pwm_generator;

  typedef struct packed {
    logic pwm;
    logic rs;
    logic fs;
  } exp_t;

  logic        clk;
  logic        RST_N;
  logic [12:0] cnt;
  logic [12:0] sh_rise, sh_fall, cur_rise, cur_fall;
  logic        en;
  logic        mprev;
  exp_t        exp_q[$];
  int          n_checks, n_errors;
  int          high_cnt, rise_cnt, fall_cnt, last_rise_t, last_fall_t;
  int          samp_cnt, first_rise_samp;

  pwm_generator_if #(.WIDTH(13)) pif ();

  pwm_generator #(.WIDTH(13)) dut (
    .CLK   (clk),
    .RST_N (RST_N),
    .bus   (pif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic model_hi(input logic [12:0] t, input logic [12:0] r,
                                    input logic [12:0] f);
    if (r == f) return 1'b0;
    else if (r < f) return (t >= r) && (t < f);
    else return (t >= r) || (t < f);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input logic hi);
    exp_t e;
    e.pwm = hi;
    e.rs  = hi & ~mprev;
    e.fs  = ~hi & mprev;
    mprev = hi;
    exp_q.push_back(e);
  endtask

  // One counter tick; emulates the upstream buffer by loading edges at TIME_CNT = 0.
  task automatic tick(input bit rel);
    @(negedge clk);
    if (rel) begin
      RST_N = 1'b1;
      push(1'b0);
    end
    if (cnt == 13'd0) begin
      cur_rise = sh_rise;
      cur_fall = sh_fall;
    end
    pif.TIME_CNT = cnt;
    pif.RISE     = cur_rise;
    pif.FALL     = cur_fall;
    pif.OUT_EN   = en;
    if (RST_N) push(model_hi(cnt, cur_rise, cur_fall) & en);
    cnt = (cnt == pif.CYCLE - 13'd1) ? 13'd0 : cnt + 13'd1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic to_zero();
    while (cnt != 13'd0) tick(1'b0);
  endtask

  task automatic clear_tally();
    high_cnt = 0; rise_cnt = 0; fall_cnt = 0;
    last_rise_t = -1; last_fall_t = -1;
    samp_cnt = 0; first_rise_samp = 0;
  endtask

  task automatic window(input string name, input int hi_n, input int r_n, input int f_n);
    run(8);
    clear_tally();
    run(4096);
    chk({name, "_high"}, high_cnt, hi_n);
    chk({name, "_rise_stb"}, rise_cnt, r_n);
    chk({name, "_fall_stb"}, fall_cnt, f_n);
  endtask

  // Monitor: compare DUT outputs against the scoreboard one sample per clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (RST_N) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_underflow: got no expected entry at t=%0d", pif.TIME_CNT);
        end else begin
          e = exp_q.pop_front();
          if ({pif.PWM_OUT, pif.RISE_STB, pif.FALL_STB} !== {e.pwm, e.rs, e.fs}) begin
            n_errors++;
            $display("FAIL sb_out t=%0d: got pwm/rs/fs %b%b%b expected %b%b%b",
                     pif.TIME_CNT, pif.PWM_OUT, pif.RISE_STB, pif.FALL_STB,
                     e.pwm, e.rs, e.fs);
          end
        end
        samp_cnt++;
        if (pif.PWM_OUT === 1'b1) high_cnt++;
        if (pif.RISE_STB === 1'b1) begin
          rise_cnt++;
          last_rise_t = int'(pif.TIME_CNT);
          if (first_rise_samp == 0) first_rise_samp = samp_cnt;
        end
        if (pif.FALL_STB === 1'b1) begin
          fall_cnt++;
          last_fall_t = int'(pif.TIME_CNT);
        end
      end
    end
  end

  initial begin
    n_checks = 0; n_errors = 0; mprev = 1'b0;
    clear_tally();
    cnt = 13'd0; en = 1'b0;
    sh_rise = 13'd0; sh_fall = 13'd0; cur_rise = 13'd0; cur_fall = 13'd0;
    pif.CYCLE = 13'd4096; pif.TIME_CNT = 13'd0; pif.RISE = 13'd0;
    pif.FALL = 13'd0; pif.OUT_EN = 1'b0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pwm", int'(pif.PWM_OUT), 0);
    chk("reset_rise_stb", int'(pif.RISE_STB), 0);
    chk("reset_fall_stb", int'(pif.FALL_STB), 0);

    // Normal pulse 100/200
    sh_rise = 13'd100; sh_fall = 13'd200; en = 1'b1;
    tick(1'b1);
    run(7);
    clear_tally();
    run(4096);
    chk("normal_high", high_cnt, 100);
    chk("normal_rise_stb", rise_cnt, 1);
    chk("normal_fall_stb", fall_cnt, 1);
    chk("normal_rise_pos", last_rise_t, 101);
    chk("normal_fall_pos", last_fall_t, 201);

    // Wrap pulse 4000/50
    sh_rise = 13'd4000; sh_fall = 13'd50;
    to_zero();
    window("wrap", 146, 1, 1);
    chk("wrap_rise_pos", last_rise_t, 4001);
    chk("wrap_fall_pos", last_fall_t, 51);

    // Zero duty and full duty
    sh_rise = 13'd300; sh_fall = 13'd300;
    to_zero();
    window("zero", 0, 0, 0);
    sh_rise = 13'd0; sh_fall = 13'd4096;
    to_zero();
    window("full", 4096, 0, 0);

    // One-tick pulse gives back-to-back strobes
    sh_rise = 13'd1000; sh_fall = 13'd1001;
    to_zero();
    window("onetick", 1, 1, 1);
    chk("onetick_rise_pos", last_rise_t, 1001);
    chk("onetick_fall_pos", last_fall_t, 1002);

    // Enable gating mid-pulse
    sh_rise = 13'd100; sh_fall = 13'd200;
    to_zero();
    run(150);
    en = 1'b0;
    clear_tally();
    run(4096);
    chk("en_high", high_cnt, 2);
    chk("en_rise_stb", rise_cnt, 0);
    chk("en_fall_stb", fall_cnt, 1);
    chk("en_fall_pos", last_fall_t, 151);
    en = 1'b1;

    // Asynchronous reset mid-pulse, release at TIME_CNT = 120
    to_zero();
    run(150);
    @(posedge clk);
    #3;
    chk("pre_reset_pwm", int'(pif.PWM_OUT), 1);
    RST_N = 1'b0;
    exp_q.delete();
    mprev = 1'b0;
    #1;
    chk("async_reset_pwm", int'(pif.PWM_OUT), 0);
    chk("async_reset_rise_stb", int'(pif.RISE_STB), 0);
    chk("async_reset_fall_stb", int'(pif.FALL_STB), 0);
    while (cnt != 13'd120) tick(1'b0);
    clear_tally();
    tick(1'b1);
    run(8);
    chk("release_first_rise_sample", first_rise_samp, 2);
    chk("release_rise_pos", last_rise_t, 121);

    // Edge update mid-cycle only takes effect at the next period start
    to_zero();
    run(150);
    sh_rise = 13'd500; sh_fall = 13'd600;
    clear_tally();
    run(3946);
    chk("buf_old_high", high_cnt, 52);
    chk("buf_old_rise_stb", rise_cnt, 0);
    chk("buf_old_fall_pos", last_fall_t, 201);
    clear_tally();
    run(4096);
    chk("buf_new_high", high_cnt, 100);
    chk("buf_new_rise_stb", rise_cnt, 1);
    chk("buf_new_fall_stb", fall_cnt, 1);
    chk("buf_new_rise_pos", last_rise_t, 501);
    chk("buf_new_fall_pos", last_fall_t, 601);

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
